// File: rtl/burst_ram_arbiter_pkg.sv
// rtl/burst_ram_arbiter_pkg.sv - shared command constants and arbiter state encoding
package burst_ram_arbiter_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT    = 3'd1,
        ST_WR_BEATS = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DRAIN    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - round-robin two-master burst arbiter in front of BurstRAM
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8,
    parameter int BURST_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          m0_req,
    input  logic                          m0_cmd,
    input  logic                          m0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     m0_addr,
    input  logic [DATA_BITWIDTH-1:0]      m0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    m0_data_mask,
    output logic [DATA_BITWIDTH-1:0]      m0_rd_data,
    output logic                          m0_rd_data_valid,
    output logic                          m0_busy,

    input  logic                          m1_req,
    input  logic                          m1_cmd,
    input  logic                          m1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     m1_addr,
    input  logic [DATA_BITWIDTH-1:0]      m1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    m1_data_mask,
    output logic [DATA_BITWIDTH-1:0]      m1_rd_data,
    output logic                          m1_rd_data_valid,
    output logic                          m1_busy,

    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]     br_addr,
    output logic [DATA_BITWIDTH-1:0]      br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]    br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
    input  logic                          br_rd_data_valid,
    input  logic                          br_busy
);

    localparam int                CNT_W     = $clog2(BURST_COUNT) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_COUNT - 1);

    arb_state_t        state, state_nxt;
    logic              owner, owner_nxt;
    logic              rr_next, rr_next_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

    logic                        own_req;
    logic                        own_cmd;
    logic                        own_cmd_en;
    logic [DEPTH_BITWIDTH-1:0]   own_addr;
    logic [DATA_BITWIDTH-1:0]    own_wr_data;
    logic [DATA_BITWIDTH/8-1:0]  own_data_mask;

    assign own_req       = owner ? m1_req       : m0_req;
    assign own_cmd       = owner ? m1_cmd       : m0_cmd;
    assign own_cmd_en    = owner ? m1_cmd_en    : m0_cmd_en;
    assign own_addr      = owner ? m1_addr      : m0_addr;
    assign own_wr_data   = owner ? m1_wr_data   : m0_wr_data;
    assign own_data_mask = owner ? m1_data_mask : m0_data_mask;

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign m0_rd_data = br_rd_data;
    assign m1_rd_data = br_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            rr_next  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_next  <= rr_next_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        rr_next_nxt      = rr_next;
        beat_cnt_nxt     = beat_cnt;
        m0_busy          = 1'b1;
        m1_busy          = 1'b1;
        m0_rd_data_valid = 1'b0;
        m1_rd_data_valid = 1'b0;
        br_cmd           = CMD_READ;
        br_cmd_en        = 1'b0;
        br_addr          = '0;
        br_wr_data       = '0;
        br_data_mask     = '0;

        if (state != ST_IDLE) begin
            br_cmd       = own_cmd;
            br_addr      = own_addr;
            br_wr_data   = own_wr_data;
            br_data_mask = own_data_mask;
        end

        case (state)
            ST_IDLE: begin
                if (!br_busy && (m0_req || m1_req)) begin
                    owner_nxt = (m0_req && m1_req) ? rr_next : m1_req;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m0_busy   = owner;
                m1_busy   = ~owner;
                br_cmd_en = own_cmd_en;
                if (own_cmd_en) begin
                    // Beat 0 of a write rides with the command strobe.
                    if (own_cmd == CMD_WRITE) begin
                        state_nxt    = ST_WR_BEATS;
                        beat_cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt    = ST_RD_WAIT;
                        beat_cnt_nxt = '0;
                    end
                end else if (!own_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_BEATS: begin
                beat_cnt_nxt = beat_cnt + CNT_W'(1);
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_RD_WAIT: begin
                m0_rd_data_valid = br_rd_data_valid && !owner;
                m1_rd_data_valid = br_rd_data_valid && owner;
                if (br_rd_data_valid) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!br_busy) begin
                    rr_next_nxt = ~owner;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - scoreboard bench for burst_ram_arbiter with a behavioural BurstRAM
module tb_burst_ram_arbiter;
    import burst_ram_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int BC = 4;
    localparam int MW = DW / 8;
    localparam int WORDS = BC * (1 << AW);

    typedef struct packed {
        logic          c_cmd;
        logic [AW-1:0] c_addr;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          m0_req = 1'b0, m0_cmd = 1'b0, m0_cmd_en = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wr_data = '0;
    logic [MW-1:0] m0_data_mask = '0;
    logic [DW-1:0] m0_rd_data;
    logic          m0_rd_data_valid, m0_busy;

    logic          m1_req = 1'b0, m1_cmd = 1'b0, m1_cmd_en = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wr_data = '0;
    logic [MW-1:0] m1_data_mask = '0;
    logic [DW-1:0] m1_rd_data;
    logic          m1_rd_data_valid, m1_busy;

    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [DW-1:0] br_rd_data;
    logic          br_rd_data_valid, br_busy;

    logic force_busy = 1'b0;
    logic spur_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_rd0[$];
    logic [DW-1:0] exp_rd1[$];
    int            exp_grant[$];
    cmd_t          exp_cmd[$];

    always #5 clk = ~clk;

    burst_ram_arbiter #(
        .DATA_BITWIDTH (DW),
        .DEPTH_BITWIDTH(AW),
        .BURST_COUNT   (BC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req          (m0_req),
        .m0_cmd          (m0_cmd),
        .m0_cmd_en       (m0_cmd_en),
        .m0_addr         (m0_addr),
        .m0_wr_data      (m0_wr_data),
        .m0_data_mask    (m0_data_mask),
        .m0_rd_data      (m0_rd_data),
        .m0_rd_data_valid(m0_rd_data_valid),
        .m0_busy         (m0_busy),
        .m1_req          (m1_req),
        .m1_cmd          (m1_cmd),
        .m1_cmd_en       (m1_cmd_en),
        .m1_addr         (m1_addr),
        .m1_wr_data      (m1_wr_data),
        .m1_data_mask    (m1_data_mask),
        .m1_rd_data      (m1_rd_data),
        .m1_rd_data_valid(m1_rd_data_valid),
        .m1_busy         (m1_busy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (br_busy)
    );

    function automatic logic [DW-1:0] pat(input int idx);
        return 64'hA5A5_0000_0000_0000 | DW'(idx);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (!mask[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

    // BurstRAM model: read data starts 3 cycles after the command, busy drops one cycle after the last beat.
    logic [DW-1:0] mem [WORDS];
    logic          ram_busy, ram_valid;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    int            ram_mode, ram_beat, ram_lat;

    assign br_busy          = ram_busy | force_busy;
    assign br_rd_data_valid = ram_valid | spur_valid;
    assign br_rd_data       = ram_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
            ram_busy  <= 1'b0;
            ram_valid <= 1'b0;
            ram_rdata <= '0;
            ram_addr  <= '0;
            ram_mode  <= 0;
            ram_beat  <= 0;
            ram_lat   <= 0;
        end else begin
            ram_valid <= 1'b0;
            case (ram_mode)
                0: if (br_cmd_en) begin
                    ram_addr <= br_addr;
                    ram_busy <= 1'b1;
                    if (br_cmd == CMD_WRITE) begin
                        mem[int'(br_addr)*BC] <= merge(mem[int'(br_addr)*BC], br_wr_data, br_data_mask);
                        ram_beat <= 1;
                        ram_mode <= 1;
                    end else begin
                        ram_beat <= 0;
                        ram_lat  <= 2;
                        ram_mode <= 2;
                    end
                end
                1: begin
                    mem[int'(ram_addr)*BC+ram_beat] <= merge(mem[int'(ram_addr)*BC+ram_beat], br_wr_data, br_data_mask);
                    if (ram_beat == BC-1) ram_mode <= 3;
                    else ram_beat <= ram_beat + 1;
                end
                2: begin
                    if (ram_lat > 0) begin
                        ram_lat <= ram_lat - 1;
                    end else begin
                        ram_valid <= 1'b1;
                        ram_rdata <= mem[int'(ram_addr)*BC+ram_beat];
                        if (ram_beat == BC-1) ram_mode <= 3;
                        else ram_beat <= ram_beat + 1;
                    end
                end
                default: begin
                    ram_busy <= 1'b0;
                    ram_mode <= 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant, a command or a read beat.
    initial begin
        logic pb0, pb1;
        cmd_t c;
        pb0 = 1'b1;
        pb1 = 1'b1;
        forever begin
            @(negedge clk);
            check("busy_exclusive", m0_busy | m1_busy, 1);
            if (pb0 && !m0_busy) begin
                if (exp_grant.size() == 0) fail("grant_unexpected_m0", 0);
                else check("grant_order", 0, exp_grant.pop_front());
            end
            if (pb1 && !m1_busy) begin
                if (exp_grant.size() == 0) fail("grant_unexpected_m1", 1);
                else check("grant_order", 1, exp_grant.pop_front());
            end
            pb0 = m0_busy;
            pb1 = m1_busy;
            if (m0_rd_data_valid) begin
                if (exp_rd0.size() == 0) fail("rd0_unexpected", m0_rd_data);
                else check("rd0_data", m0_rd_data, exp_rd0.pop_front());
            end
            if (m1_rd_data_valid) begin
                if (exp_rd1.size() == 0) fail("rd1_unexpected", m1_rd_data);
                else check("rd1_data", m1_rd_data, exp_rd1.pop_front());
            end
            if (br_cmd_en) begin
                if (exp_cmd.size() == 0) begin
                    fail("br_cmd_en_unexpected", br_addr);
                end else begin
                    c = exp_cmd.pop_front();
                    check("br_cmd", br_cmd, c.c_cmd);
                    check("br_addr", br_addr, c.c_addr);
                end
            end
        end
    end

    task automatic set_req(input int n, input logic v);
        if (n == 0) m0_req = v; else m1_req = v;
    endtask

    task automatic drive(input int n, input logic en, input logic cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        if (n == 0) begin
            m0_cmd_en = en; m0_cmd = cmd; m0_addr = addr; m0_wr_data = wd; m0_data_mask = '0;
        end else begin
            m1_cmd_en = en; m1_cmd = cmd; m1_addr = addr; m1_wr_data = wd; m1_data_mask = '0;
        end
    endtask

    task automatic set_wdata(input int n, input logic [DW-1:0] wd);
        if (n == 0) m0_wr_data = wd; else m1_wr_data = wd;
    endtask

    // For writes beats are the data sent; for reads they are the data expected back.
    task automatic do_burst(input int n, input logic cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] beats [BC], input logic keep_req);
        bit got;
        got = 1'b0;
        set_req(n, 1'b1);
        for (int c = 0; c < 400 && !got; c++) begin
            @(posedge clk); #1;
            got = (n == 0) ? !m0_busy : !m1_busy;
        end
        if (!got) begin
            fail("grant_timeout", n);
            set_req(n, 1'b0);
            return;
        end
        exp_cmd.push_back(cmd_t'{c_cmd: cmd, c_addr: addr});
        if (cmd == CMD_READ) begin
            for (int i = 0; i < BC; i++) begin
                if (n == 0) exp_rd0.push_back(beats[i]); else exp_rd1.push_back(beats[i]);
            end
        end
        drive(n, 1'b1, cmd, addr, beats[0]);
        @(posedge clk); #1;
        drive(n, 1'b0, cmd, addr, beats[0]);
        if (!keep_req) set_req(n, 1'b0);
        check("busy_after_cmd", (n == 0) ? m0_busy : m1_busy, 1);
        if (cmd == CMD_WRITE) begin
            for (int i = 1; i < BC; i++) begin
                set_wdata(n, beats[i]);
                @(posedge clk); #1;
            end
        end
        set_wdata(n, '0);
    endtask

    task automatic do_read(input int n, input logic [AW-1:0] addr, input logic keep_req);
        logic [DW-1:0] e [BC];
        for (int i = 0; i < BC; i++) e[i] = pat(int'(addr)*BC + i);
        do_burst(n, CMD_READ, addr, e, keep_req);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_rd0.size() == 0 && exp_rd1.size() == 0 && exp_grant.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_rd0.size() + exp_rd1.size() + exp_grant.size() + exp_cmd.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_m0_busy", m0_busy, 1);
        check("rst_m1_busy", m1_busy, 1);
        check("rst_m0_rd_valid", m0_rd_data_valid, 0);
        check("rst_m1_rd_valid", m1_rd_data_valid, 0);
        check("rst_br_cmd_en", br_cmd_en, 0);
        check("rst_br_cmd", br_cmd, 0);
        check("rst_br_addr", br_addr, 0);
        check("rst_br_wr_data", br_wr_data, 0);
        check("rst_br_data_mask", br_data_mask, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v [BC];
        int cnt;
        bit got;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous contention from reset: strict alternation starting with m0.
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            begin
                for (int k = 0; k < 3; k++) do_read(0, AW'(8'h10 + k), k < 2);
            end
            begin
                for (int k = 0; k < 3; k++) do_read(1, AW'(8'h20 + k), k < 2);
            end
        join
        wait_drain();

        // m1 write then read back the same burst.
        v = '{64'h11, 64'h22, 64'h33, 64'h44};
        exp_grant.push_back(1);
        do_burst(1, CMD_WRITE, 8'h09, v, 1'b0);
        exp_grant.push_back(1);
        do_burst(1, CMD_READ, 8'h09, v, 1'b0);
        wait_drain();

        // m0 alone reads burst 5 = RAM words 20..23.
        v = '{64'hA5A5_0000_0000_0014, 64'hA5A5_0000_0000_0015,
              64'hA5A5_0000_0000_0016, 64'hA5A5_0000_0000_0017};
        exp_grant.push_back(0);
        do_burst(0, CMD_READ, 8'h05, v, 1'b0);
        wait_drain();

        // m1 withdraws its request; round-robin pointer must still favour m1.
        exp_grant.push_back(1);
        m1_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk); #1;
            got = !m1_busy;
        end
        if (!got) fail("withdraw_grant_timeout", 1);
        m1_req = 1'b0;
        @(posedge clk); #1;
        check("withdraw_busy", m1_busy, 1);
        repeat (3) @(posedge clk);
        #1;
        exp_grant.push_back(1); exp_grant.push_back(0);
        fork
            do_read(1, 8'h30, 1'b0);
            do_read(0, 8'h31, 1'b0);
        join
        wait_drain();

        // RAM busy gates the grant.
        force_busy = 1'b1;
        m0_req = 1'b1;
        exp_grant.push_back(0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("gate_busy_held", m0_busy, 1);
        end
        force_busy = 1'b0;
        @(posedge clk); #1;
        check("gate_grant_next", m0_busy, 0);
        do_read(0, 8'h40, 1'b0);
        wait_drain();

        // Spurious read-valid in IDLE is dropped.
        spur_valid = 1'b1;
        @(negedge clk);
        check("spur_m0_valid", m0_rd_data_valid, 0);
        check("spur_m1_valid", m1_rd_data_valid, 0);
        @(posedge clk); #1;
        spur_valid = 1'b0;
        exp_grant.push_back(1);
        do_read(1, 8'h41, 1'b0);
        wait_drain();

        // Reset after the second read beat.
        exp_grant.push_back(0);
        do_read(0, 8'h07, 1'b0);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 2; c++) begin
            @(negedge clk);
            if (m0_rd_data_valid) cnt++;
        end
        check("mid_reset_beats_seen", cnt, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_rd0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_grant.push_back(0);
        do_read(0, 8'h0A, 1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
# burst_ram_arbiter

Two-master arbiter that shares one `BurstRAM` between the instruction-side and data-side cache refill/write-back engines. It grants the RAM to one master for exactly one burst (read or write), routes command, write beats and read beats, then releases. It uses round-robin fairness. It sits between the cache controllers and `BurstRAM`. Every master-side port mirrors the `br_*` interface, plus one request line.

## Interface
- `DATA_BITWIDTH`, 64, burst beat width
- `DEPTH_BITWIDTH`, 8, RAM address width (burst-aligned word address)
- `BURST_COUNT`, 4, beats per burst (power of 2, ≥2)

- `clk`  in  1  single clock, shared with `BurstRAM`
- `rst_n`  in  1  asynchronous, active-low reset
- `mN_req`  in  1  (N=0,1) level request; held until the master's `mN_cmd_en` is issued
- `mN_cmd`  in  1  0 = read, 1 = write
- `mN_cmd_en`  in  1  command strobe, legal only while `mN_busy`=0
- `mN_addr`  in  DEPTH_BITWIDTH  burst address
- `mN_wr_data`  in  DATA_BITWIDTH  write beat
- `mN_data_mask`  in  DATA_BITWIDTH/8  byte mask (1 = masked)
- `mN_rd_data`  out  DATA_BITWIDTH  read beat (broadcast of `br_rd_data`)
- `mN_rd_data_valid`  out  1  read beat valid, owner only
- `mN_busy`  out  1  0 only while master N holds the grant and may issue
- `br_cmd`, `br_cmd_en`, `br_addr`, `br_wr_data`, `br_data_mask`  out  to `BurstRAM`
- `br_rd_data`, `br_rd_data_valid`, `br_busy`  in  from `BurstRAM`

## Operation
- States: IDLE, GRANT, WR_BEATS, RD_WAIT, DRAIN. Registered `owner` (1 bit), `rr_next` (1 bit), `beat_cnt` ($clog2(BURST_COUNT)+1 bits).
- IDLE: if `br_busy`=0 and any `req` is set, pick a master. If both request, take `rr_next`; otherwise take the one requester. Latch it into `owner` and go to GRANT.
- GRANT: `m<owner>_busy`=0. On `m<owner>_cmd_en`:
  - Forward the command combinationally to `br_*` in the same cycle.
  - Write goes to WR_BEATS with `beat_cnt`=1 (beat 0 travels with cmd_en).
  - Read goes to RD_WAIT with `beat_cnt`=0.
  - If the owner drops `req` without cmd_en, return to IDLE. `rr_next` is unchanged.
- WR_BEATS: the owner presents one beat per cycle with no stalls. The arbiter forwards `wr_data`/`data_mask` and increments `beat_cnt`. At `BURST_COUNT` it goes to DRAIN.
- RD_WAIT: each `br_rd_data_valid` raises `m<owner>_rd_data_valid` and increments `beat_cnt`. At `BURST_COUNT` it goes to DRAIN.
- DRAIN: wait for `br_busy`=0. Then set `rr_next` = ~`owner` and go to IDLE.
- `br_cmd_en` is 0 outside GRANT. `br_wr_data`/`br_data_mask`/`br_addr`/`br_cmd` mux from `owner`. They are 0 in IDLE.
- Non-owner: `mN_busy`=1 and `mN_rd_data_valid`=0 at all times.

## Timing
- Reset values: state IDLE, `owner`=0, `rr_next`=0, `beat_cnt`=0. Both `mN_busy`=1, all `mN_rd_data_valid`=0, `br_cmd_en`=0, all `br_*` outputs 0.
- Grant latency: `req` sampled high in IDLE at edge k, so `mN_busy`=0 during cycle k+1. A command can issue in that same cycle.
- `mN_busy` returns to 1 the cycle after cmd_en. It is never low for two masters simultaneously.
- Read data path: zero added latency, combinational from `br_rd_data_valid`.
- Simultaneous requests in IDLE: `rr_next` wins. Strict alternation holds under continuous contention.
- `br_busy`=1 in IDLE: no grant until it clears.
- Spurious `br_rd_data_valid` outside RD_WAIT is dropped and not counted.
- `rst_n` low mid-burst: immediate return to reset values. `BurstRAM` shares `rst_n`, so it also aborts, and no beats are owed afterwards.

## Structure
- A shared package holds the `CMD_READ`=0 / `CMD_WRITE`=1 constants and the state enum encoding. The cache uses the same `CMD_*` constants.
- A single module with no sub-modules. A 2-input round-robin select is small enough to stay inline.

## Test plan
- Read, m0 alone: `m0_req`=1, cmd_en read addr 0x05. Expect `br_addr`=0x05 and `br_cmd_en`=1 in the same cycle, then 4 `m0_rd_data_valid` beats equal to RAM words 20..23. `m1_rd_data_valid` stays 0.
- Write then read, m1: write addr 0x09 with beats 0x11..0x44 and mask 0. Then read 0x09. Expect 0x11,0x22,0x33,0x44 back in order.
- Contention: both `req` asserted in the same cycle after reset. Expect m0 granted first, then m1. With both held continuously over 6 bursts, expect the grant order 0,1,0,1,0,1.
- Request withdrawn: m1 granted, drops `req` without cmd_en. Expect a return to IDLE with no `br_cmd_en`. The next contention still goes to m1.
- Reset mid-read: assert `rst_n`=0 after the 2nd read beat. Expect all outputs at reset values immediately. After release, a new m0 read completes normally.
- Gating: hold `br_busy`=1 with `m0_req`=1. Expect `m0_busy` to stay 1 until `br_busy` drops, then the grant on the next cycle.
